// File: rtl/ram_dma_burst_ci.sv
// Custom-instruction slave with a local word memory and a burst DMA engine
// that moves blocks between the local memory and the system bus, in either
// direction, byte-reversing every word on the way through.
module ram_dma_burst_ci #(
    parameter logic [7:0] customId   = 8'h00,
    parameter int         MEM_ADDR_W = 9,
    parameter int         BLOCK_W    = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    input  logic [31:0] addressDataIn,
    input  logic        endTransactionIn,
    input  logic        dataValidIn,
    input  logic        busErrorIn,
    input  logic        busyIn,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        irq
);

    localparam int DEPTH = 1 << MEM_ADDR_W;
    localparam int LW    = (BLOCK_W > 9) ? BLOCK_W : 9;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        BEGIN,
        READ_DATA,
        WRITE_DATA,
        WRITE_END,
        ERROR_WAIT
    } state_t;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t state, state_nxt;

    // custom-instruction decode
    logic                  ci_hit, ci_wr, ci_rd;
    logic [2:0]            ci_idx;
    logic [MEM_ADDR_W-1:0] ci_addr;
    logic                  busy;
    logic                  unused_va;

    // configuration and status registers
    logic [31:0]           bus_start;
    logic [MEM_ADDR_W-1:0] mem_start;
    logic [BLOCK_W-1:0]    block_size;
    logic [7:0]            burst_m1;
    logic [1:0]            irq_en;
    logic                  complete, error, dir_read;

    // transfer counters
    logic [31:0]           bus_addr;
    logic [MEM_ADDR_W-1:0] mem_ptr, mem_ptr_nxt;
    logic [BLOCK_W-1:0]    remaining, remaining_nxt;
    logic [8:0]            beats_left;
    logic [LW-1:0]         burst_plus1, remaining_ext, burst_len;

    // control strobes
    logic start_xfer, rd_accept, wr_accept, adv;
    logic set_complete, set_error, load_beats;
    logic clr_complete, clr_error;

    // local memory ports
    logic [31:0]           mem [0:DEPTH-1];
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic [31:0]           ci_rdata, dma_rdata;

    // CI read pipeline
    logic                  rd_p1;
    logic [2:0]            rd_idx1;
    logic [31:0]           reg_rdata, reg_snap;

    assign ci_hit    = start && (ciN == customId);
    assign ci_idx    = valueA[12:10];
    assign ci_wr     = ci_hit && valueA[9];
    assign ci_rd     = ci_hit && !valueA[9];
    assign ci_addr   = valueA[MEM_ADDR_W-1:0];
    assign busy      = (state != IDLE);
    assign unused_va = ^valueA[31:13];

    assign start_xfer   = ci_wr && (ci_idx == 3'd5) && !busy &&
                          ((valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10));
    assign clr_complete = ci_wr && (ci_idx == 3'd7) && valueB[4];
    assign clr_error    = ci_wr && (ci_idx == 3'd7) && valueB[5];

    assign rd_accept = (state == READ_DATA) && dataValidIn && !busErrorIn &&
                       (remaining != '0);
    assign wr_accept = (state == WRITE_DATA) && !busyIn && !busErrorIn;
    assign adv       = rd_accept || wr_accept;

    // next values of the pointer and word counter, shared by the FSM decision
    always_comb begin
        mem_ptr_nxt   = mem_ptr;
        remaining_nxt = remaining;
        if (start_xfer) begin
            mem_ptr_nxt   = mem_start;
            remaining_nxt = block_size;
        end else if (adv) begin
            mem_ptr_nxt   = mem_ptr + MEM_ADDR_W'(1);
            remaining_nxt = remaining - BLOCK_W'(1);
        end
    end

    // length of the next burst: configured length clipped to what is left
    always_comb begin
        burst_plus1   = LW'(burst_m1) + LW'(1);
        remaining_ext = LW'(remaining);
        burst_len     = (burst_plus1 < remaining_ext) ? burst_plus1 : remaining_ext;
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and bus-side outputs
    always_comb begin
        state_nxt           = state;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        endTransactionOut   = 1'b0;
        dataValidOut        = 1'b0;
        readNotWriteOut     = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        set_complete        = 1'b0;
        set_error           = 1'b0;
        load_beats          = 1'b0;
        case (state)
            IDLE: begin
                if (start_xfer) begin
                    if (block_size == '0) set_complete = 1'b1;
                    else                  state_nxt    = REQUEST;
                end
            end
            REQUEST: begin
                requestTransaction = 1'b1;
                if (transactionGranted) state_nxt = BEGIN;
            end
            BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = bus_addr;
                byteEnablesOut      = 4'hF;
                burstSizeOut        = 8'(burst_len - LW'(1));
                readNotWriteOut     = dir_read;
                load_beats          = 1'b1;
                state_nxt           = dir_read ? READ_DATA : WRITE_DATA;
            end
            READ_DATA: begin
                if (busErrorIn) begin
                    set_error = 1'b1;
                    state_nxt = endTransactionIn ? IDLE : ERROR_WAIT;
                end else if (endTransactionIn) begin
                    // a word delivered together with the end strobe still counts
                    if (remaining_nxt == '0) begin
                        set_complete = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        state_nxt = REQUEST;
                    end
                end
            end
            WRITE_DATA: begin
                dataValidOut   = 1'b1;
                addressDataOut = bswap(dma_rdata);
                if (busErrorIn) begin
                    set_error = 1'b1;
                    state_nxt = endTransactionIn ? IDLE : ERROR_WAIT;
                end else if (wr_accept && (beats_left == 9'd1)) begin
                    state_nxt = WRITE_END;
                end
            end
            WRITE_END: begin
                endTransactionOut = 1'b1;
                if (remaining == '0) begin
                    set_complete = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    state_nxt = REQUEST;
                end
            end
            ERROR_WAIT: begin
                if (endTransactionIn) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // transfer counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_addr   <= '0;
            mem_ptr    <= '0;
            remaining  <= '0;
            beats_left <= '0;
        end else begin
            mem_ptr   <= mem_ptr_nxt;
            remaining <= remaining_nxt;
            if (start_xfer)  bus_addr <= bus_start;
            else if (adv)    bus_addr <= bus_addr + 32'd4;
            if (load_beats)     beats_left <= 9'(burst_len);
            else if (wr_accept) beats_left <= beats_left - 9'd1;
        end
    end

    // software-visible configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_start  <= '0;
            mem_start  <= '0;
            block_size <= '0;
            burst_m1   <= '0;
            irq_en     <= '0;
            dir_read   <= 1'b0;
        end else begin
            if (ci_wr && !busy) begin
                case (ci_idx)
                    3'd1:    bus_start  <= valueB;
                    3'd2:    mem_start  <= valueB[MEM_ADDR_W-1:0];
                    3'd3:    block_size <= valueB[BLOCK_W-1:0];
                    3'd4:    burst_m1   <= valueB[7:0];
                    default: ;
                endcase
            end
            if (ci_wr && (ci_idx == 3'd7)) irq_en <= valueB[1:0];
            if (start_xfer) dir_read <= (valueB[1:0] == 2'b01);
        end
    end

    // sticky flags (a set wins over a same-cycle clear) and the interrupt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            complete <= 1'b0;
            error    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (set_complete)                   complete <= 1'b1;
            else if (start_xfer || clr_complete) complete <= 1'b0;
            if (set_error)                      error <= 1'b1;
            else if (start_xfer || clr_error)   error <= 1'b0;
            irq <= (complete && irq_en[0]) || (error && irq_en[1]);
        end
    end

    assign mem_we    = (ci_wr && (ci_idx == 3'd0) && !busy) || rd_accept;
    assign mem_waddr = rd_accept ? mem_ptr : ci_addr;
    assign mem_wdata = rd_accept ? bswap(addressDataIn) : valueB;

    // local memory: one write port, CI read port and DMA prefetch port;
    // dma_rdata always holds the word at the pointer's current value
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        ci_rdata  <= mem[ci_addr];
        dma_rdata <= mem[mem_ptr_nxt];
    end

    // register read multiplexer
    always_comb begin
        reg_rdata = '0;
        case (ci_idx)
            3'd1:    reg_rdata = bus_start;
            3'd2:    reg_rdata = 32'(mem_start);
            3'd3:    reg_rdata = 32'(block_size);
            3'd4:    reg_rdata = 32'(burst_m1);
            3'd5:    reg_rdata = {29'd0, busy, error, complete};
            3'd6:    reg_rdata = 32'(remaining);
            3'd7:    reg_rdata = {30'd0, irq_en};
            default: reg_rdata = '0;
        endcase
    end

    // CI completion: writes finish next cycle, reads after the memory stage;
    // register values are captured at the start cycle so reads see pre-event state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_p1    <= 1'b0;
            rd_idx1  <= '0;
            reg_snap <= '0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            rd_p1    <= ci_rd;
            rd_idx1  <= ci_idx;
            reg_snap <= reg_rdata;
            done     <= ci_wr || rd_p1;
            result   <= rd_p1 ? ((rd_idx1 == 3'd0) ? ci_rdata : reg_snap) : '0;
        end
    end

endmodule

// File: tb/tb_ram_dma_burst_ci.sv
// Directed bench: register/memory vectors from a table, then hand-written
// DMA sequences with a simple bus-slave behaviour driven inline.
module tb_ram_dma_burst_ci;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic        done;
    logic [31:0] result;
    logic        requestTransaction, transactionGranted;
    logic [31:0] addressDataIn;
    logic        endTransactionIn, dataValidIn, busErrorIn, busyIn;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    ram_dma_burst_ci #(
        .customId  (8'h00),
        .MEM_ADDR_W(9),
        .BLOCK_W   (10)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .ciN                (ciN),
        .valueA             (valueA),
        .valueB             (valueB),
        .done               (done),
        .result             (result),
        .requestTransaction (requestTransaction),
        .transactionGranted (transactionGranted),
        .addressDataIn      (addressDataIn),
        .endTransactionIn   (endTransactionIn),
        .dataValidIn        (dataValidIn),
        .busErrorIn         (busErrorIn),
        .busyIn             (busyIn),
        .addressDataOut     (addressDataOut),
        .byteEnablesOut     (byteEnablesOut),
        .burstSizeOut       (burstSizeOut),
        .readNotWriteOut    (readNotWriteOut),
        .beginTransactionOut(beginTransactionOut),
        .endTransactionOut  (endTransactionOut),
        .dataValidOut       (dataValidOut),
        .irq                (irq)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic ci_write(input logic [2:0] idx, input logic [8:0] addr, input logic [31:0] data);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {19'd0, idx, 1'b1, addr};
        valueB = data;
        tick;
        start  = 1'b0;
        valueA = '0;
        valueB = '0;
        check1("ci_write_done", done, 1'b1);
    endtask

    task automatic ci_read(input logic [2:0] idx, input logic [8:0] addr, output logic [31:0] data);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {19'd0, idx, 1'b0, addr};
        valueB = '0;
        tick;
        start  = 1'b0;
        valueA = '0;
        check1("ci_read_done_early", done, 1'b0);
        tick;
        check1("ci_read_done", done, 1'b1);
        data = result;
    endtask

    // wait for the bus request, grant it, check the begin cycle, step into data phase
    task automatic grant_begin(input logic [31:0] exp_addr, input logic [7:0] exp_bs, input logic exp_rnw);
        int t = 0;
        while (!requestTransaction && t < 50) begin
            tick;
            t++;
        end
        check1("request", requestTransaction, 1'b1);
        transactionGranted = 1'b1;
        tick;
        transactionGranted = 1'b0;
        check1("begin", beginTransactionOut, 1'b1);
        check("begin_addr", addressDataOut, exp_addr);
        check("begin_be", 32'(byteEnablesOut), 32'h0000000F);
        check("begin_burst", 32'(burstSizeOut), 32'(exp_bs));
        check1("begin_rnw", readNotWriteOut, exp_rnw);
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          len, k, hold, cyc;

        vt[0]  = '{1'b1, 3'd0, 9'd5,   32'h11223344, 32'h0};
        vt[1]  = '{1'b0, 3'd0, 9'd5,   32'h0,        32'h11223344};
        vt[2]  = '{1'b0, 3'd5, 9'd0,   32'h0,        32'h0};
        vt[3]  = '{1'b0, 3'd6, 9'd0,   32'h0,        32'h0};
        vt[4]  = '{1'b1, 3'd1, 9'd0,   32'hDEADBEEF, 32'h0};
        vt[5]  = '{1'b0, 3'd1, 9'd0,   32'h0,        32'hDEADBEEF};
        vt[6]  = '{1'b1, 3'd2, 9'd0,   32'hFFFFF0A3, 32'h0};
        vt[7]  = '{1'b0, 3'd2, 9'd0,   32'h0,        32'h000000A3};
        vt[8]  = '{1'b1, 3'd3, 9'd0,   32'h0000FFFF, 32'h0};
        vt[9]  = '{1'b0, 3'd3, 9'd0,   32'h0,        32'h000003FF};
        vt[10] = '{1'b1, 3'd4, 9'd0,   32'h00001234, 32'h0};
        vt[11] = '{1'b0, 3'd4, 9'd0,   32'h0,        32'h00000034};
        vt[12] = '{1'b1, 3'd7, 9'd0,   32'h000000F3, 32'h0};
        vt[13] = '{1'b0, 3'd7, 9'd0,   32'h0,        32'h00000003};
        vt[14] = '{1'b1, 3'd0, 9'h1FF, 32'hCAFEF00D, 32'h0};
        vt[15] = '{1'b0, 3'd0, 9'h1FF, 32'h0,        32'hCAFEF00D};
        vt[16] = '{1'b1, 3'd5, 9'd0,   32'h00000003, 32'h0};
        vt[17] = '{1'b0, 3'd5, 9'd0,   32'h0,        32'h0};
        vt[18] = '{1'b1, 3'd7, 9'd0,   32'h0,        32'h0};
        vt[19] = '{1'b0, 3'd0, 9'd5,   32'h0,        32'h11223344};

        reset = 1'b1;
        start = 1'b0;
        ciN = '0;
        valueA = '0;
        valueB = '0;
        transactionGranted = 1'b0;
        addressDataIn = '0;
        endTransactionIn = 1'b0;
        dataValidIn = 1'b0;
        busErrorIn = 1'b0;
        busyIn = 1'b0;

        #12;
        check1("reset_outputs", |{done, result, requestTransaction, addressDataOut,
                                  byteEnablesOut, burstSizeOut, readNotWriteOut,
                                  beginTransactionOut, endTransactionOut, dataValidOut, irq}, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick;

        // register and memory access table
        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) begin
                ci_write(vt[i].idx, vt[i].addr, vt[i].data);
            end else begin
                ci_read(vt[i].idx, vt[i].addr, r);
                check($sformatf("vec%0d", i), r, vt[i].exp);
            end
        end

        // read transfer: 10 words in bursts of 4, 4, 2
        ci_write(3'd1, 9'd0, 32'h00001000);
        ci_write(3'd2, 9'd0, 32'd16);
        ci_write(3'd3, 9'd0, 32'd10);
        ci_write(3'd4, 9'd0, 32'd3);
        ci_write(3'd5, 9'd0, 32'd1);
        for (int b = 0; b < 3; b++) begin
            len = (b == 2) ? 2 : 4;
            grant_begin(32'h00001000 + 32'(16 * b), 8'(len - 1), 1'b1);
            for (int j = 0; j < len; j++) begin
                dataValidIn      = 1'b1;
                addressDataIn    = 32'hA0B0C000 + 32'(4 * b + j);
                endTransactionIn = (j == len - 1);
                tick;
            end
            dataValidIn      = 1'b0;
            endTransactionIn = 1'b0;
            addressDataIn    = '0;
        end
        ci_read(3'd5, 9'd0, r);
        check("rd_xfer_status", r, 32'h1);
        ci_read(3'd6, 9'd0, r);
        check("rd_xfer_remaining", r, 32'h0);
        for (int i = 0; i < 10; i++) begin
            ci_read(3'd0, 9'(16 + i), r);
            check($sformatf("rd_xfer_mem%0d", i), r, bswap(32'hA0B0C000 + 32'(i)));
        end

        // write transfer: 5 words in one burst, slave busy 3 cycles on word 2
        for (int i = 0; i < 5; i++) ci_write(3'd0, 9'(40 + i), 32'h10203040 + 32'(i));
        ci_write(3'd1, 9'd0, 32'h00002000);
        ci_write(3'd2, 9'd0, 32'd40);
        ci_write(3'd3, 9'd0, 32'd5);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_write(3'd5, 9'd0, 32'd2);
        grant_begin(32'h00002000, 8'd4, 1'b0);
        k = 0;
        hold = 0;
        cyc = 0;
        while (k < 5 && cyc < 30) begin
            check1("wr_dv", dataValidOut, 1'b1);
            check("wr_data", addressDataOut, bswap(32'h10203040 + 32'(k)));
            if (k == 2 && hold < 3) begin
                busyIn = 1'b1;
                hold++;
            end else begin
                busyIn = 1'b0;
                k++;
            end
            tick;
            cyc++;
        end
        busyIn = 1'b0;
        check("wr_words_accepted", 32'(k), 32'd5);
        check1("wr_end", endTransactionOut, 1'b1);
        check1("wr_end_dv", dataValidOut, 1'b0);
        tick;
        check1("wr_end_single", endTransactionOut, 1'b0);
        check1("wr_no_request", requestTransaction, 1'b0);
        ci_read(3'd6, 9'd0, r);
        check("wr_remaining", r, 32'h0);
        ci_read(3'd5, 9'd0, r);
        check("wr_status", r, 32'h1);

        // bus error on word 2 without end strobe, error interrupt enabled
        ci_write(3'd7, 9'd0, 32'h2);
        ci_write(3'd1, 9'd0, 32'h00003000);
        ci_write(3'd2, 9'd0, 32'd60);
        ci_write(3'd3, 9'd0, 32'd4);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_write(3'd5, 9'd0, 32'd1);
        grant_begin(32'h00003000, 8'd3, 1'b1);
        dataValidIn = 1'b1;
        addressDataIn = 32'h11110000;
        tick;
        addressDataIn = 32'h11110001;
        tick;
        addressDataIn = 32'h11110002;
        busErrorIn = 1'b1;
        tick;
        dataValidIn = 1'b0;
        busErrorIn = 1'b0;
        addressDataIn = '0;
        check1("err_wait_no_request", requestTransaction, 1'b0);
        ci_read(3'd5, 9'd0, r);
        check("err_wait_status", r, 32'h6);
        check1("err_wait_irq", irq, 1'b1);
        endTransactionIn = 1'b1;
        tick;
        endTransactionIn = 1'b0;
        ci_read(3'd5, 9'd0, r);
        check("err_status", r, 32'h2);
        check1("err_irq", irq, 1'b1);
        ci_read(3'd6, 9'd0, r);
        check("err_remaining", r, 32'h2);
        ci_write(3'd7, 9'd0, 32'h22);
        tick;
        check1("err_irq_cleared", irq, 1'b0);
        ci_read(3'd5, 9'd0, r);
        check("err_status_cleared", r, 32'h0);

        // zero-length block completes without touching the bus
        ci_write(3'd3, 9'd0, 32'd0);
        ci_write(3'd5, 9'd0, 32'd1);
        check1("zero_no_request", requestTransaction, 1'b0);
        tick;
        tick;
        check1("zero_no_request_later", requestTransaction, 1'b0);
        ci_read(3'd5, 9'd0, r);
        check("zero_status", r, 32'h1);

        // memory pointer wraps from the last word to word 0
        ci_write(3'd1, 9'd0, 32'h00004000);
        ci_write(3'd2, 9'd0, 32'd511);
        ci_write(3'd3, 9'd0, 32'd2);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_write(3'd5, 9'd0, 32'd1);
        grant_begin(32'h00004000, 8'd1, 1'b1);
        dataValidIn = 1'b1;
        addressDataIn = 32'h01234567;
        tick;
        addressDataIn = 32'h89ABCDEF;
        endTransactionIn = 1'b1;
        tick;
        dataValidIn = 1'b0;
        endTransactionIn = 1'b0;
        addressDataIn = '0;
        ci_read(3'd0, 9'd511, r);
        check("wrap_last", r, 32'h67452301);
        ci_read(3'd0, 9'd0, r);
        check("wrap_first", r, 32'hEFCDAB89);
        ci_read(3'd5, 9'd0, r);
        check("wrap_status", r, 32'h1);

        // reset in the middle of a write burst
        ci_write(3'd1, 9'd0, 32'h00005000);
        ci_write(3'd2, 9'd0, 32'd40);
        ci_write(3'd3, 9'd0, 32'd5);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_write(3'd5, 9'd0, 32'd2);
        grant_begin(32'h00005000, 8'd4, 1'b0);
        busyIn = 1'b1;
        check1("rst_in_write_data", dataValidOut, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check1("rst_async_outputs", |{done, result, requestTransaction, addressDataOut,
                                      byteEnablesOut, burstSizeOut, readNotWriteOut,
                                      beginTransactionOut, endTransactionOut, dataValidOut, irq}, 1'b0);
        tick;
        tick;
        check1("rst_no_end", endTransactionOut, 1'b0);
        busyIn = 1'b0;
        reset = 1'b0;
        tick;
        ci_read(3'd5, 9'd0, r);
        check("rst_status_idle", r, 32'h0);
        ci_read(3'd3, 9'd0, r);
        check("rst_block_size", r, 32'h0);
        check1("rst_irq", irq, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
